// File: rtl/lc_fetch_ctl.sv
// lc_fetch_ctl: macro-instruction fetch sequencer for the location counter.
// Owns the byte-address LC, fetches the containing memory word on demand and
// presents halfwords (or zero-extended bytes) to the decoder via valid/ready.
// Optional word prefetch buffer enabled by defining LC_PREFETCH_EN.
module lc_fetch_ctl #(
    parameter int unsigned LC_W   = 26,
    parameter int unsigned WORD_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              lc_load,
    input  logic [LC_W-1:0]   lc_load_val,
    input  logic              byte_mode,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [15:0]       instr,
    output logic              mem_req,
    output logic [LC_W-3:0]   mem_addr,
    input  logic              mem_ack,
    input  logic [WORD_W-1:0] mem_data,
    input  logic              mem_err,
    output logic [LC_W-1:0]   lc,
    output logic              needfetch,
    output logic              fault
);

    localparam int unsigned WA_W = LC_W - 2;

    typedef enum logic [2:0] {
        ST_EMPTY   = 3'd0,
        ST_FETCH   = 3'd1,
        ST_FULL    = 3'd2,
        ST_DISCARD = 3'd3,
        ST_FAULT   = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [LC_W-1:0]     lc_q, lc_d;
    logic [WORD_W-1:0]   buf_q, buf_d;
    logic [WA_W-1:0]     buf_addr_q, buf_addr_d;
    logic                buf_valid_q, buf_valid_d;
    logic                mem_req_q, mem_req_d;
    logic [WA_W-1:0]     mem_addr_q, mem_addr_d;
    logic                fault_q, fault_d;

`ifdef LC_PREFETCH_EN
    logic [WORD_W-1:0]   pf_data_q, pf_data_d;
    logic [WA_W-1:0]     pf_addr_q, pf_addr_d;
    logic                pf_valid_q, pf_valid_d;
    logic                pf_req_q, pf_req_d;
`endif

    logic [2:0]          step_c;
    logic [2:0]          low_sum_c;
    logic                cross_c;
    logic [LC_W-1:0]     lc_inc_c;
    logic                advance_c;

    // Advance arithmetic: next LC and carry out of lc[1] (word crossing)
    always_comb begin
        step_c    = byte_mode ? 3'd1 : 3'd2;
        low_sum_c = {1'b0, lc_q[1:0]} + step_c;
        cross_c   = low_sum_c[2];
        lc_inc_c  = lc_q + LC_W'(step_c);
    end

    assign instr_valid = (state_q == ST_FULL) && !lc_load;
    assign advance_c   = instr_valid && instr_ready;
    assign needfetch   = !(buf_valid_q && (buf_addr_q == lc_q[LC_W-1:2]));

    // Select the halfword or byte addressed by LC from the buffered word
    always_comb begin
        instr = 16'h0000;
        if (byte_mode) begin
            case (lc_q[1:0])
                2'd0:    instr = {8'h00, buf_q[7:0]};
                2'd1:    instr = {8'h00, buf_q[15:8]};
                2'd2:    instr = {8'h00, buf_q[23:16]};
                default: instr = {8'h00, buf_q[31:24]};
            endcase
        end else begin
            instr = lc_q[1] ? buf_q[31:16] : buf_q[15:0];
        end
    end

    // Next-state and register-update logic
    always_comb begin
        state_d     = state_q;
        lc_d        = lc_q;
        buf_d       = buf_q;
        buf_addr_d  = buf_addr_q;
        buf_valid_d = buf_valid_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        fault_d     = fault_q;
`ifdef LC_PREFETCH_EN
        pf_data_d   = pf_data_q;
        pf_addr_d   = pf_addr_q;
        pf_valid_d  = pf_valid_q;
        pf_req_d    = pf_req_q;
`endif

        if (lc_load) begin
            // Load wins over everything; an unanswered request must still be drained
            lc_d        = lc_load_val;
            buf_valid_d = 1'b0;
            fault_d     = 1'b0;
`ifdef LC_PREFETCH_EN
            pf_valid_d  = 1'b0;
`endif
            if (mem_req_q && !mem_ack) begin
                state_d = ST_DISCARD;
            end else begin
                state_d   = ST_EMPTY;
                mem_req_d = 1'b0;
`ifdef LC_PREFETCH_EN
                pf_req_d  = 1'b0;
`endif
            end
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    state_d    = ST_FETCH;
                    mem_req_d  = 1'b1;
                    mem_addr_d = lc_q[LC_W-1:2];
`ifdef LC_PREFETCH_EN
                    pf_req_d   = 1'b0;
`endif
                end

                ST_FETCH: begin
                    if (mem_ack) begin
                        mem_req_d = 1'b0;
`ifdef LC_PREFETCH_EN
                        pf_req_d  = 1'b0;
`endif
                        if (mem_err) begin
`ifdef LC_PREFETCH_EN
                            // A failed prefetch being waited on is retried as a demand fetch
                            if (pf_req_q) begin
                                state_d = ST_EMPTY;
                            end else begin
                                state_d = ST_FAULT;
                                fault_d = 1'b1;
                            end
`else
                            state_d = ST_FAULT;
                            fault_d = 1'b1;
`endif
                        end else begin
                            state_d     = ST_FULL;
                            buf_d       = mem_data;
                            buf_addr_d  = mem_addr_q;
                            buf_valid_d = 1'b1;
                        end
                    end
                end

                ST_FULL: begin
`ifdef LC_PREFETCH_EN
                    // Complete an outstanding prefetch, or start one when idle
                    if (mem_req_q && mem_ack) begin
                        mem_req_d = 1'b0;
                        pf_req_d  = 1'b0;
                        if (!mem_err) begin
                            pf_valid_d = 1'b1;
                            pf_data_d  = mem_data;
                            pf_addr_d  = mem_addr_q;
                        end
                    end else if (!mem_req_q && !pf_valid_q) begin
                        mem_req_d  = 1'b1;
                        mem_addr_d = lc_q[LC_W-1:2] + WA_W'(1);
                        pf_req_d   = 1'b1;
                    end
`endif
                    if (advance_c) begin
                        lc_d = lc_inc_c;
                        if (cross_c) begin
                            buf_valid_d = 1'b0;
`ifdef LC_PREFETCH_EN
                            pf_valid_d  = 1'b0;
                            if (pf_valid_q && (pf_addr_q == lc_inc_c[LC_W-1:2])) begin
                                // Promote prefetched word without a bubble
                                buf_d       = pf_data_q;
                                buf_addr_d  = pf_addr_q;
                                buf_valid_d = 1'b1;
                            end else if (mem_req_q && pf_req_q &&
                                         (mem_addr_q == lc_inc_c[LC_W-1:2])) begin
                                // Needed word is already in flight: wait for it
                                if (mem_ack) begin
                                    mem_req_d = 1'b0;
                                    pf_req_d  = 1'b0;
                                    if (!mem_err) begin
                                        buf_d       = mem_data;
                                        buf_addr_d  = mem_addr_q;
                                        buf_valid_d = 1'b1;
                                    end else begin
                                        state_d = ST_EMPTY;
                                    end
                                end else begin
                                    state_d = ST_FETCH;
                                end
                            end else if (mem_req_q && !mem_ack) begin
                                state_d = ST_DISCARD;
                            end else begin
                                state_d   = ST_EMPTY;
                                mem_req_d = 1'b0;
                                pf_req_d  = 1'b0;
                            end
`else
                            state_d = ST_EMPTY;
`endif
                        end
                    end
                end

                ST_DISCARD: begin
                    // Drop the abandoned response, then refetch at the new LC
                    if (mem_ack) begin
                        mem_req_d = 1'b0;
                        state_d   = ST_EMPTY;
`ifdef LC_PREFETCH_EN
                        pf_req_d  = 1'b0;
`endif
                    end
                end

                ST_FAULT: begin
                    mem_req_d = 1'b0;
                    fault_d   = 1'b1;
                end

                default: begin
                    state_d   = ST_EMPTY;
                    mem_req_d = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers, synchronous active-high reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            lc_q        <= '0;
            buf_q       <= '0;
            buf_addr_q  <= '0;
            buf_valid_q <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            lc_q        <= lc_d;
            buf_q       <= buf_d;
            buf_addr_q  <= buf_addr_d;
            buf_valid_q <= buf_valid_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            fault_q     <= fault_d;
        end
    end

`ifdef LC_PREFETCH_EN
    // Prefetch buffer registers
    always_ff @(posedge clk) begin
        if (reset) begin
            pf_data_q  <= '0;
            pf_addr_q  <= '0;
            pf_valid_q <= 1'b0;
            pf_req_q   <= 1'b0;
        end else begin
            pf_data_q  <= pf_data_d;
            pf_addr_q  <= pf_addr_d;
            pf_valid_q <= pf_valid_d;
            pf_req_q   <= pf_req_d;
        end
    end
`endif

    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;
    assign lc       = lc_q;
    assign fault    = fault_q;

endmodule
